// File: rtl/parallel_serial.sv
// rtl/parallel_serial.sv - 10-bit symbol serializer, MSB first, comma fill and alignment preamble
module parallel_serial #(
  parameter logic [9:0]  COMMA       = 10'b0011111010,
  parameter int unsigned INIT_COMMAS = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] DATA_IN,
  input  logic       VALID_IN,
  input  logic       TX_EN,
  output logic       READY,
  output logic       DATA_OUT,
  output logic       SYM_START,
  output logic       IDLE
);

  typedef enum logic {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // With a single preamble comma the reset comma already covers it.
  localparam state_t     RST_STATE = (INIT_COMMAS == 1) ? ST_ACTIVE : ST_INIT;
  // init_cnt value at the load edge that ends the preamble.
  localparam logic [3:0] INIT_LAST = 4'(INIT_COMMAS - 1);

  state_t     state_q, state_d;
  logic [9:0] shreg_q, shreg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic       idle_q, idle_d;
  logic       load;
  logic       ready;

  assign load  = (bit_cnt_q == 4'd9);
  assign ready = (state_q == ST_ACTIVE) && TX_EN && load;

  assign READY     = ready;
  assign DATA_OUT  = shreg_q[9];
  assign SYM_START = (bit_cnt_q == 4'd0);
  assign IDLE      = idle_q;

  // State register and datapath flops; reset leaves a comma on the line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= RST_STATE;
      shreg_q    <= COMMA;
      bit_cnt_q  <= 4'd0;
      init_cnt_q <= 4'd1;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      init_cnt_q <= init_cnt_d;
      idle_q     <= idle_d;
    end
  end

  // Preamble FSM: count commas at each load edge, then go active for good.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (load && (state_q == ST_INIT)) begin
      init_cnt_d = init_cnt_q + 4'd1;
      if (init_cnt_q == INIT_LAST) begin
        state_d = ST_ACTIVE;
      end
    end
  end

  // Shift out one bit per cycle; on the last bit load data or a fill comma.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    idle_d    = idle_q;
    if (!load) begin
      shreg_d   = {shreg_q[8:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end else begin
      bit_cnt_d = 4'd0;
      if (VALID_IN && ready) begin
        shreg_d = DATA_IN;
        idle_d  = 1'b0;
      end else begin
        shreg_d = COMMA;
        idle_d  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_serial.sv
// tb/tb_parallel_serial.sv - directed self-checking bench for parallel_serial
module tb_parallel_serial;

  localparam logic [9:0] K = 10'b0011111010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] data_in;
  logic       valid_in;
  logic       tx_en;
  logic       ready;
  logic       data_out;
  logic       sym_start;
  logic       idle;

  int total = 0;
  int bad   = 0;

  parallel_serial dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .DATA_IN  (data_in),
    .VALID_IN (valid_in),
    .TX_EN    (tx_en),
    .READY    (ready),
    .DATA_OUT (data_out),
    .SYM_START(sym_start),
    .IDLE     (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check the first n cycles of a symbol, starting at a negedge.
  task automatic sym(input string tag, input logic [9:0] s, input logic idl,
                     input logic rdy_end, input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("%s.dout[%0d]", tag, k), data_out, s[9-k]);
      chk($sformatf("%s.sstart[%0d]", tag, k), sym_start, (k == 0));
      chk($sformatf("%s.ready[%0d]", tag, k), ready, rdy_end && (k == 9));
      chk($sformatf("%s.idle[%0d]", tag, k), idle, idl);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    data_in  = 10'h000;
    valid_in = 1'b0;
    tx_en    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.dout", data_out, 1'b0);
    chk("rst.sstart", sym_start, 1'b1);
    chk("rst.idle", idle, 1'b1);
    chk("rst.ready", ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preamble: four commas, READY only on the last bit of the fourth.
    sym("init0", K, 1'b1, 1'b0, 10);
    sym("init1", K, 1'b1, 1'b0, 10);
    sym("init2", K, 1'b1, 1'b0, 10);
    valid_in = 1'b1;
    data_in  = 10'h2AA;
    sym("init3", K, 1'b1, 1'b1, 10);
    sym("d2aa_a", 10'h2AA, 1'b0, 1'b1, 10);
    data_in = 10'h3FF;
    sym("d2aa_b", 10'h2AA, 1'b0, 1'b1, 10);
    data_in = 10'h000;
    sym("d3ff", 10'h3FF, 1'b0, 1'b1, 10);
    valid_in = 1'b0;
    data_in  = 10'h155;
    sym("d000", 10'h000, 1'b0, 1'b1, 10);

    // TX_EN low in ACTIVE: commas only even with VALID_IN high.
    valid_in = 1'b1;
    tx_en    = 1'b0;
    sym("fill0", K, 1'b1, 1'b0, 10);
    sym("txoff", K, 1'b1, 1'b0, 10);
    tx_en = 1'b1;
    sym("txon", K, 1'b1, 1'b1, 10);
    valid_in = 1'b0;
    data_in  = 10'h0F0;
    sym("d155", 10'h155, 1'b0, 1'b1, 10);

    // Reset in the middle of a comma.
    sym("part", K, 1'b1, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    chk("mrst.dout", data_out, 1'b0);
    chk("mrst.sstart", sym_start, 1'b1);
    chk("mrst.idle", idle, 1'b1);
    chk("mrst.ready", ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sym("re0", K, 1'b1, 1'b0, 10);
    sym("re1", K, 1'b1, 1'b0, 10);
    sym("re2", K, 1'b1, 1'b0, 10);
    sym("re3", K, 1'b1, 1'b1, 10);
    sym("re4", K, 1'b1, 1'b1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_serial.md
Name: parallel_serial

Overview:
Transmit-side counterpart of the serial_parallel receiver. Accepts 10-bit encoded symbols over a valid/ready handshake and shifts them out one bit per CLK cycle, MSB (bit 9) first. After reset it sends a fixed run of comma symbols so the receiver can align. When no data is offered it fills the line with commas, so the serial stream never stalls.

Parameters:
COMMA, 10'b0011111010, idle/alignment symbol (K28.5, RD-); loaded on reset and whenever no data is accepted
INIT_COMMAS, 4, number of commas sent after reset before data is accepted; legal range 1..15

Ports:
CLK  input  1  clock; all state updates on the rising edge
RESET  input  1  asynchronous, active-low reset (RESET=0 resets)
DATA_IN  input  10  parallel symbol to transmit; bit 9 is sent first
VALID_IN  input  1  DATA_IN holds a symbol to send
TX_EN  input  1  1 = accept data; 0 = send commas only
READY  output  1  the block accepts DATA_IN at this edge if VALID_IN=1
DATA_OUT  output  1  serial bit stream
SYM_START  output  1  DATA_OUT carries bit 9 of a symbol
IDLE  output  1  the symbol currently on DATA_OUT is a comma

Behaviour:
- Registers:
  - shreg[9:0]: shift register.
  - bit_cnt[3:0]: counts 0..9.
  - init_cnt[3:0]: comma counter for the INIT phase.
  - state: INIT or ACTIVE.
  - idle_r: registered comma flag behind IDLE.
- Output mapping:
  - DATA_OUT = shreg[9], driven by a register with no combinational path from inputs.
  - SYM_START = (bit_cnt==0).
  - IDLE = idle_r.
- RESET=0 forces, asynchronously:
  - shreg=COMMA, bit_cnt=0, init_cnt=1, idle_r=1.
  - state=INIT, or ACTIVE if INIT_COMMAS==1.
  - Resulting outputs: DATA_OUT=COMMA[9]=0, SYM_START=1, IDLE=1, READY=0.
- Each rising edge with bit_cnt!=9: shreg <= {shreg[8:0],1'b0}; bit_cnt++.
- Load edge (bit_cnt==9): bit_cnt <= 0.
  - If VALID_IN && READY: shreg <= DATA_IN, idle_r <= 0.
  - Otherwise: shreg <= COMMA, idle_r <= 1.
- READY = (state==ACTIVE) && TX_EN && (bit_cnt==9).
  - Combinational from registers and TX_EN only; never depends on VALID_IN.
  - READY is high for exactly 1 cycle in every 10.
- Handshake and latency:
  - A symbol transfers at an edge where VALID_IN=1 and READY=1.
  - Its bit 9 appears on DATA_OUT in the next cycle; bits 9..0 occupy 10 consecutive cycles.
  - VALID_IN with READY=0 is ignored; the source holds the symbol.
- State machine:
  - INIT: each load edge loads COMMA and increments init_cnt. When init_cnt+1==INIT_COMMAS, state <= ACTIVE at that same edge, so exactly INIT_COMMAS commas precede the first data symbol.
  - ACTIVE: remains until reset.
- Cycle numbering: cycle 0 is the first cycle after RESET rises; bit k of symbol n appears at cycle 10n+k.
- Boundary conditions:
  - TX_EN low in ACTIVE: commas only. TX_EN changing mid-symbol affects only the next load edge.
  - Back-to-back data: VALID_IN held high gives continuous data with no gap commas.
  - Reset mid-symbol: the partial symbol is discarded; after release the sequence restarts with INIT commas.
  - bit_cnt never exceeds 9.
  - DATA_IN is sampled only at transfer edges.

Test Plan:
- Reset release, INIT_COMMAS=4, VALID_IN=0 -> DATA_OUT cycles 0-39 = 0011111010 repeated 4x. READY=0 through cycle 38, READY=1 at cycle 39. SYM_START=1 at cycles 0, 10, 20, 30.
- VALID_IN=1, DATA_IN=10'h2AA held from cycle 30 -> accepted at the cycle-39 edge. Cycles 40-49 = 1010101010, IDLE=0. Symbol 5 (cycles 50-59) is again 10'h2AA while VALID stays high.
- Back-to-back 10'h3FF then 10'h000 with VALID continuous -> cycles 40-49 all 1, cycles 50-59 all 0, no comma between them.
- VALID_IN dropped after one transfer -> next symbol is COMMA with IDLE=1. READY pulses every 10 cycles at cycles 49, 59, ...
- TX_EN=0 in ACTIVE with VALID_IN=1 -> READY stays 0 and only commas are sent. TX_EN=1 before cycle 59 -> data starts at cycle 60.
- RESET low at cycle 44, high at cycle 46 -> DATA_OUT=0 and SYM_START=1 immediately. Then 4 commas restart from the release, and READY first rises 39 cycles after release.
